// File: rtl/pipe_pkg.sv
// Pipeline-wide shared definitions.
//
// Provides the default bubble encoding used by every pipeline register stage,
// the maximum bundle width and the state encoding of the optional skid buffer.
package pipe_pkg;

  // Bubble encoding: addi x0, x0, 0.
  localparam logic [31:0] PIPE_NOP_INST = 32'h0000_0013;

  // Widest instruction bundle the pipeline supports.
  localparam int unsigned PIPE_MAX_LANES = 4;

  // Occupancy of a stage that carries a skid entry behind its main entry.
  typedef enum logic [1:0] {
    SkEmpty    = 2'd0,
    SkMain     = 2'd1,
    SkMainSkid = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_lane_mux.sv
// Per-lane output select for a pipeline register stage.
//
// Presents the held instruction and PC of one lane when that lane is live,
// otherwise the bubble encoding and a zero PC.
//
// Ports:
//   i_vld   - lane is live (bundle valid and lane qualifier set)
//   i_inst  - held instruction for this lane
//   i_pc    - held PC for this lane
//   o_inst  - instruction driven downstream (NOP_INST when not live)
//   o_pc    - PC driven downstream (zero when not live)
module pipe_lane_mux
  import pipe_pkg::*;
#(
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       PC_W     = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(PIPE_NOP_INST)
) (
  input  logic              i_vld,
  input  logic [INST_W-1:0] i_inst,
  input  logic [PC_W-1:0]   i_pc,
  output logic [INST_W-1:0] o_inst,
  output logic [PC_W-1:0]   o_pc
);

  always_comb begin
    o_inst = NOP_INST;
    o_pc   = '0;
    if (i_vld) begin
      o_inst = i_inst;
      o_pc   = i_pc;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline register stage for multi-lane instruction bundles.
//
// Holds one bundle (or two with the skid entry), with valid/ready handshakes on
// both sides, flush, bubble insertion on dead lanes and a saturating stall
// counter. Defining PIPE_STAGE_SKID_EN adds a skid entry so that in_ready is a
// register with no combinational path from out_ready.
//
// Ports:
//   clk, rst       - clock (rising edge), asynchronous active-high reset
//   flush          - kill held and incoming bundles
//   in_valid       - upstream bundle valid
//   in_lane_vld    - upstream per-lane qualifier
//   in_inst, in_pc - upstream lanes, lane i at [i*W +: W]
//   in_ready       - stage can accept a bundle
//   out_valid      - downstream bundle valid
//   out_lane_vld   - downstream per-lane qualifier
//   out_inst       - downstream instructions (NOP_INST on dead lanes)
//   out_pc         - downstream PCs (zero on dead lanes)
//   out_ready      - downstream accepts; low means stall
//   stall_cnt      - saturating count of stalled cycles, cleared only by reset
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       LANES    = 2,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       PC_W     = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(PIPE_NOP_INST),
  parameter int unsigned       CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [LANES-1:0]        in_lane_vld,
  input  logic [LANES*INST_W-1:0] in_inst,
  input  logic [LANES*PC_W-1:0]   in_pc,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [LANES-1:0]        out_lane_vld,
  output logic [LANES*INST_W-1:0] out_inst,
  output logic [LANES*PC_W-1:0]   out_pc,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic                    w_valid;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_load_main;
  logic [LANES-1:0]        w_src_lane_vld;
  logic [LANES*INST_W-1:0] w_src_inst;
  logic [LANES*PC_W-1:0]   w_src_pc;
  logic [LANES-1:0]        w_lane_en;

  logic [LANES-1:0]        r_lane_vld;
  logic [LANES*INST_W-1:0] r_inst;
  logic [LANES*PC_W-1:0]   r_pc;
  logic [CNT_W-1:0]        r_stall_cnt;

  // A bundle offered during flush is discarded, never loaded.
  assign w_in_fire  = in_valid & in_ready & ~flush;
  assign w_out_fire = w_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  skid_state_e             r_state;
  skid_state_e             w_state_d;
  logic                    r_in_ready;
  logic                    w_load_skid;
  logic                    w_main_from_skid;
  logic [LANES-1:0]        r_skid_lane_vld;
  logic [LANES*INST_W-1:0] r_skid_inst;
  logic [LANES*PC_W-1:0]   r_skid_pc;

  assign w_valid  = (r_state != SkEmpty);
  assign in_ready = r_in_ready;

  always_comb begin
    w_state_d        = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_d = SkEmpty;
    end else begin
      unique case (r_state)
        SkEmpty: begin
          if (w_in_fire) begin
            w_state_d   = SkMain;
            w_load_main = 1'b1;
          end
        end
        SkMain: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main = 1'b1;
          end else if (w_in_fire) begin
            w_state_d   = SkMainSkid;
            w_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_d = SkEmpty;
          end
        end
        SkMainSkid: begin
          // in_ready is low here, so only the drain of main can happen.
          if (w_out_fire) begin
            w_state_d        = SkMain;
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_d = SkEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SkEmpty;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_in_ready <= (w_state_d != SkMainSkid);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_lane_vld <= '0;
      r_skid_inst     <= '0;
      r_skid_pc       <= '0;
    end else if (flush) begin
      r_skid_lane_vld <= '0;
    end else if (w_load_skid) begin
      r_skid_lane_vld <= in_lane_vld;
      r_skid_inst     <= in_inst;
      r_skid_pc       <= in_pc;
    end
  end

  assign w_src_lane_vld = w_main_from_skid ? r_skid_lane_vld : in_lane_vld;
  assign w_src_inst     = w_main_from_skid ? r_skid_inst     : in_inst;
  assign w_src_pc       = w_main_from_skid ? r_skid_pc       : in_pc;
`else
  logic r_valid;
  logic w_valid_d;

  assign w_valid  = r_valid;
  // Accept whenever the held bundle leaves this cycle or nothing is held.
  assign in_ready = out_ready | ~r_valid;

  always_comb begin
    w_valid_d   = r_valid;
    w_load_main = 1'b0;
    if (flush) begin
      w_valid_d = 1'b0;
    end else if (w_in_fire) begin
      w_valid_d   = 1'b1;
      w_load_main = 1'b1;
    end else if (w_out_fire) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_valid_d;
    end
  end

  assign w_src_lane_vld = in_lane_vld;
  assign w_src_inst     = in_inst;
  assign w_src_pc       = in_pc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane_vld <= '0;
      r_inst     <= '0;
      r_pc       <= '0;
    end else if (flush) begin
      r_lane_vld <= '0;
    end else if (w_load_main) begin
      r_lane_vld <= w_src_lane_vld;
      r_inst     <= w_src_inst;
      r_pc       <= w_src_pc;
    end
  end

  // Counts stalled cycles, including the cycle a flush lands in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign w_lane_en    = r_lane_vld & {LANES{w_valid}};
  assign out_valid    = w_valid;
  assign out_lane_vld = w_lane_en;
  assign stall_cnt    = r_stall_cnt;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pipe_lane_mux #(
      .INST_W  (INST_W),
      .PC_W    (PC_W),
      .NOP_INST(NOP_INST)
    ) u_lane_mux (
      .i_vld (w_lane_en[g]),
      .i_inst(r_inst[g*INST_W +: INST_W]),
      .i_pc  (r_pc[g*PC_W +: PC_W]),
      .o_inst(out_inst[g*INST_W +: INST_W]),
      .o_pc  (out_pc[g*PC_W +: PC_W])
    );
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed cases plus randomized traffic,
// with a queue-based reference of the held bundles and a separate monitor.
module tb_pipe_stage_reg;
  localparam int unsigned LANES = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_lane_vld = '0;
  logic [63:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [1:0]  out_lane_vld;
  logic [63:0] out_inst, out_pc;
  logic [15:0] stall_cnt;
  logic        s_in_ready, s_out_valid;
  logic [1:0]  s_out_lane_vld;
  logic [63:0] s_out_inst, s_out_pc;
  logic [2:0]  s_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_lane_vld(in_lane_vld),
    .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid),
    .out_lane_vld(out_lane_vld), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .stall_cnt(stall_cnt)
  );

  // Narrow counter instance sharing the same stimulus, for saturation.
  pipe_stage_reg #(.LANES(LANES), .CNT_W(3)) dut_w3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_lane_vld(in_lane_vld),
    .in_inst(in_inst), .in_pc(in_pc), .in_ready(s_in_ready), .out_valid(s_out_valid),
    .out_lane_vld(s_out_lane_vld), .out_inst(s_out_inst), .out_pc(s_out_pc),
    .out_ready(out_ready), .stall_cnt(s_stall_cnt)
  );

  typedef struct packed {
    logic [1:0]  lv;
    logic [63:0] inst;
    logic [63:0] pc;
  } bundle_t;

  bundle_t     exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int unsigned m_cnt = 0;
  int unsigned m_cnt_s = 0;
  logic        exp_in_ready = 1'b1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: the stage is a FIFO of capacity CAP; accepted bundles are queued.
  task automatic pred_step();
    bundle_t b;
    if (rst) return;
    if (flush) begin
      exp_q.delete();
    end else if (in_valid && exp_in_ready) begin
      b.lv   = in_lane_vld;
      b.inst = in_inst;
      b.pc   = in_pc;
      exp_q.push_back(b);
    end
  endtask

  task automatic mon_step();
    bundle_t     b;
    logic        ev, eir;
    logic [1:0]  elv;
    logic [63:0] einst, epc;
    if (rst) begin
      exp_q.delete();
      m_cnt        = 0;
      m_cnt_s      = 0;
      exp_in_ready = 1'b1;
      return;
    end
    ev    = (exp_q.size() > 0);
    elv   = '0;
    einst = {NOP, NOP};
    epc   = '0;
    if (ev) begin
      b = exp_q[0];
      for (int i = 0; i < LANES; i++) begin
        if (b.lv[i]) begin
          elv[i]            = 1'b1;
          einst[i*32 +: 32] = b.inst[i*32 +: 32];
          epc[i*32 +: 32]   = b.pc[i*32 +: 32];
        end
      end
    end
`ifdef PIPE_STAGE_SKID_EN
    eir = (exp_q.size() < CAP);
`else
    eir = out_ready || !ev;
`endif
    chk("mon_out_valid", out_valid, ev);
    chk("mon_out_lane_vld", out_lane_vld, elv);
    chk("mon_out_inst", out_inst, einst);
    chk("mon_out_pc", out_pc, epc);
    chk("mon_in_ready", in_ready, eir);
    chk("mon_stall_cnt", stall_cnt, m_cnt[15:0]);
    chk("mon_w3_out_valid", s_out_valid, ev);
    chk("mon_w3_stall_cnt", s_stall_cnt, m_cnt_s[2:0]);
    exp_in_ready = eir;
    if (ev && out_ready) void'(exp_q.pop_front());
    if (ev && !out_ready) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 7) m_cnt_s++;
    end
  endtask

  always @(posedge clk) pred_step();
  always @(negedge clk) mon_step();

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [1:0] lv, input logic [31:0] pc0);
    in_valid    = v;
    in_lane_vld = lv;
    in_pc       = {pc0 + 32'd4, pc0};
    in_inst     = {pc0 ^ 32'h5A5A_0000, pc0 ^ 32'h0000_A5A5};
  endtask

  initial begin
    // Reset values.
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_lane_vld", out_lane_vld, 2'b00);
    chk("rst_out_inst", out_inst, {32'h0000_0013, 32'h0000_0013});
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_stall_cnt", stall_cnt, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Lane 0 live, lane 1 dead.
    in_valid    = 1'b1;
    in_lane_vld = 2'b01;
    in_inst     = {32'hAAAA_AAAA, 32'h0000_0093};
    in_pc       = {32'h0000_0104, 32'h0000_0100};
    out_ready   = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("b1_out_valid", out_valid, 1'b1);
    chk("b1_lane_vld", out_lane_vld, 2'b01);
    chk("b1_lane0_pc", out_pc[31:0], 32'h0000_0100);
    chk("b1_lane0_inst", out_inst[31:0], 32'h0000_0093);
    chk("b1_lane1_pc", out_pc[63:32], 32'h0);
    chk("b1_lane1_inst", out_inst[63:32], 32'h0000_0013);

    // Stall: outputs stable, counter counts and saturates in the narrow instance.
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'h300);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_pc_stable", out_pc, {32'h304, 32'h300});
      chk("stall_valid_stable", out_valid, 1'b1);
    end
    chk("stall_cnt_5", stall_cnt, 16'd5);
    repeat (5) cyc();
    chk("stall_cnt_10", stall_cnt, 16'd10);
    chk("stall_cnt_w3_sat", s_stall_cnt, 3'd7);

    // Flush beats stall and kills the bundle offered in the same cycle.
    flush = 1'b1;
    drive(1'b1, 2'b11, 32'hDEAD_0000);
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_lane_vld", out_lane_vld, 2'b00);
    chk("flush_out_pc", out_pc, 64'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_never_appears", out_valid, 1'b0);
    end

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 32'h400);
    cyc();
    in_valid = 1'b0;
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_lane_vld", out_lane_vld, 2'b00);
    chk("arst_out_inst", out_inst, {32'h0000_0013, 32'h0000_0013});
    chk("arst_out_pc", out_pc, 64'h0);
    chk("arst_stall_cnt", stall_cnt, 16'h0);
    chk("arst_w3_stall_cnt", s_stall_cnt, 3'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 32'h200);
    cyc();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_pc", out_pc, {32'h204, 32'h200});

`ifdef PIPE_STAGE_SKID_EN
    // Back-to-back stream through a one-cycle stall.
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 32'h0);
    cyc();
    chk("skid_t1_pc", out_pc[31:0], 32'h0);
    chk("skid_t1_in_ready", in_ready, 1'b1);
    drive(1'b1, 2'b11, 32'h8);
    out_ready = 1'b0;
    cyc();
    chk("skid_t2_in_ready", in_ready, 1'b0);
    chk("skid_t2_pc", out_pc[31:0], 32'h0);
    drive(1'b1, 2'b11, 32'h10);
    out_ready = 1'b1;
    cyc();
    chk("skid_t3_pc", out_pc[31:0], 32'h8);
    chk("skid_t3_in_ready", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("skid_t4_pc", out_pc[31:0], 32'h10);
    cyc();
    chk("skid_t5_empty", out_valid, 1'b0);
`endif

    // Randomized traffic against the reference queue.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_lane_vld = 2'($urandom_range(0, 3));
      in_inst     = {$urandom, $urandom};
      in_pc       = {$urandom, $urandom};
      out_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 31) == 0);
      cyc();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL take parameter LANES, default 2: number of instruction lanes per bundle, legal range 1..4.
REQ-002 SHALL take parameter INST_W, default 32: instruction width per lane.
REQ-003 SHALL take parameter PC_W, default 32: PC width per lane.
REQ-004 SHALL take parameter NOP_INST, default 32'h0000_0013: bubble encoding (addi x0,x0,0).
REQ-005 SHALL take parameter CNT_W, default 16: stall-counter width.
REQ-006 SHALL have port clk, input, 1: clock, rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port flush, input, 1: kill all held and incoming instructions (branch/jump taken).
REQ-009 SHALL have port in_valid, input, 1: upstream bundle valid.
REQ-010 SHALL have port in_lane_vld, input, LANES: per-lane qualifier.
REQ-011 SHALL have port in_inst, input, LANES*INST_W: lane i at bits [i*INST_W +: INST_W].
REQ-012 SHALL have port in_pc, input, LANES*PC_W: lane PCs, packed the same way.
REQ-013 SHALL have port in_ready, output, 1: stage can accept a bundle.
REQ-014 SHALL have port out_valid, output, 1: downstream bundle valid.
REQ-015 SHALL have port out_lane_vld, output, LANES: per-lane qualifier.
REQ-016 SHALL have ports out_inst, output, LANES*INST_W, and out_pc, output, LANES*PC_W: downstream instructions and PCs.
REQ-017 SHALL have port out_ready, input, 1: downstream accepts; low means stall.
REQ-018 SHALL have port stall_cnt, output, CNT_W: stall-cycle counter.

Function
REQ-019 SHALL accept a bundle when in_valid and in_ready are both high at a clk edge, and present it on out_* the following cycle (latency 1).
REQ-020 SHALL complete an output transfer when out_valid and out_ready are both high; out_* SHALL hold stable while out_valid is high and out_ready is low.
REQ-021 SHALL drive out_inst lane to NOP_INST and out_pc lane to 0 for every lane whose out_lane_vld bit is 0, and for all lanes when out_valid is 0.
REQ-022 SHALL, on flush, clear all held entries: out_valid=0 and out_lane_vld=0 the next cycle, and discard any bundle offered in the same cycle.
REQ-023 SHALL give flush priority over stall when flush and out_ready=0 occur together.
REQ-024 SHALL complete both transfers in one cycle when an input beat and an output beat coincide (pass-through, no bubble).
REQ-025 SHALL increment stall_cnt each cycle with out_valid=1 and out_ready=0, saturate at all-ones, and never clear except on reset.
REQ-026 SHALL never drop or duplicate a bundle absent flush.

Reset
REQ-027 SHALL, while rst is high, force out_valid=0, out_lane_vld=0, all out_inst lanes=NOP_INST, out_pc=0, stall_cnt=0, and empty the skid entry.
REQ-028 SHALL discard held and incoming bundles when rst is asserted mid-operation; the first accepted bundle after deassertion SHALL appear with normal latency 1.

Configuration
REQ-029 SHALL, without PIPE_STAGE_SKID_EN, derive in_ready = out_ready | ~out_valid combinationally (single entry).
REQ-030 SHALL, with PIPE_STAGE_SKID_EN, add one skid entry and register in_ready = ~skid_full, so in_ready has no combinational path from out_ready.
REQ-031 SHALL, with PIPE_STAGE_SKID_EN, use states EMPTY, MAIN, MAIN+SKID with these transitions:
- EMPTY->MAIN on input.
- MAIN->MAIN+SKID on input while out_ready=0.
- MAIN->EMPTY on output without input.
- MAIN+SKID->MAIN on output (skid moves to main).
- Any state->EMPTY on flush.

Structure
REQ-032 SHALL take NOP_INST's default value and the skid-state enum from a shared package (pipe_pkg), alongside the other pipeline-wide constants.
REQ-033 SHALL instantiate one sub-module, pipe_lane_mux, LANES times, to select NOP/0 versus held inst/pc per lane.

Verification
REQ-034 Bench SHALL check that, after reset, out_valid=0, out_inst lanes read 32'h0000_0013, out_pc=0 and stall_cnt=0.
REQ-035 Bench SHALL check that a bundle with in_lane_vld=2'b01, pc=32'h100, out_ready=1 gives next cycle: out_valid=1, lane0 pc=32'h100, lane1=NOP/pc 0.
REQ-036 Bench SHALL hold out_ready=0 for 5 cycles with out_valid=1 and check out_* stable and stall_cnt=5; with CNT_W=3, 10 stall cycles give stall_cnt=7.
REQ-037 Bench SHALL assert flush with out_ready=0 and in_valid=1 and check next cycle out_valid=0 and that the offered bundle never appears.
REQ-038 Bench SHALL, with PIPE_STAGE_SKID_EN, stream back-to-back bundles pc 0x0,0x8,0x10 while out_ready is low for one cycle, and check all three emerge in order, none lost, and in_ready drops only after the skid fills.
REQ-039 Bench SHALL pulse rst mid-stall and check all outputs reach reset values asynchronously, before the next clk edge.
